steering_pwm_driver: RTL
========================

# steering_pwm_driver

Consumes the PID steering command (valid strobe + signed 48-bit value) produced at the output of the autonomous-driving top and drives a hobby-servo PWM line. The block scales and clamps the command to a pulse width and applies it only at PWM period boundaries. It rate-limits width changes per period, and falls back to the neutral pulse when commands stop arriving.

## Interface
- PERIOD_CYCLES, 1_000_000: PWM period in clk cycles (20 ms @ 50 MHz).
- PULSE_MIN, 50_000: minimum pulse width, cycles.
- PULSE_CENTER, 75_000: neutral pulse width, cycles.
- PULSE_MAX, 100_000: maximum pulse width, cycles.
- CTRL_SHIFT, 16: arithmetic right shift mapping the command to a pulse offset in cycles.
- RATE_STEP, 1_000: maximum width change per period, cycles.
- TIMEOUT_PERIODS, 10: consecutive periods without a command before failsafe.
- W = $clog2(PERIOD_CYCLES+1): width of the counter and pulse-width fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_ctrl_valid  in  1  command strobe, single cycle.
- i_ctrl_value  in  48 signed  steering command.
- i_enable  in  1  level; low forces idle.
- o_pwm  out  1  servo PWM, registered.
- o_period_start  out  1  one-cycle pulse on period cycle 0, registered.
- o_pulse_width  out  W  width currently being output.
- o_saturated  out  1  last accepted command was clamped.
- o_timeout  out  1  high while in FAILSAFE.

## Operation
- **Capture stage.** Runs in 1 cycle on i_ctrl_valid.
  - offset = i_ctrl_value >>> CTRL_SHIFT, arithmetic shift, so it floors toward −∞.
  - sum = PULSE_CENTER + offset, computed in 50-bit signed.
  - target is sum clamped to [PULSE_MIN, PULSE_MAX].
  - o_saturated is set when the clamp was active.
  - Capture is independent of state; the latest command within a period wins.
- **Period counter.** Counts 0..PERIOD_CYCLES−1 and wraps. It runs only when i_enable=1.
- **Boundary update.** Occurs at counter==PERIOD_CYCLES−1, so it takes effect from the next cycle 0.
  - goal = PULSE_CENTER in FAILSAFE, otherwise target.
  - width moves toward goal by min(|goal−width|, RATE_STEP).
- **Miss counter.**
  - Increments at each boundary with no command since the previous boundary.
  - Clears on any i_ctrl_valid.
  - Saturates at TIMEOUT_PERIODS.
- **Output.** o_pwm = (counter < width) while in RUN or FAILSAFE.
- **FSM states.** IDLE, RUN, FAILSAFE.
  - IDLE → RUN when i_enable=1. The counter starts at 0 the next cycle, and width = PULSE_CENTER.
  - RUN → FAILSAFE at a boundary where the miss count reaches TIMEOUT_PERIODS.
  - FAILSAFE → RUN at the first boundary after an i_ctrl_valid.
  - Any state → IDLE when i_enable=0, taking effect the next cycle:
    - o_pwm=0, counter=0, width=PULSE_CENTER;
    - target and the miss count are retained.

## Timing
- **Reset values (any time, including mid-pulse):**
  - state IDLE, counter 0;
  - width = target = PULSE_CENTER;
  - o_pwm=0, o_period_start=0, o_saturated=0, o_timeout=0, miss count 0.
- **Command latency.** A command updates target one cycle after i_ctrl_valid. It affects o_pwm from the first period that starts after the next boundary.
- **Output alignment.** o_pwm and o_period_start are registered from the same counter value, so they are aligned.
  - o_pwm is high for exactly width cycles starting with the o_period_start cycle.
  - width=0 is never possible: PULSE_MIN>0.
- **Valid on the boundary cycle.** The boundary uses the previously registered target; the new command applies one period later. The miss count is still cleared, so no timeout is counted.
- **Width register.** o_pulse_width changes only on the cycle-0 transition and stays constant within a period.
- **Enable drop.** o_pwm goes low one cycle after i_enable falls, even mid-pulse. There is no glitch pulse on re-enable.
- **Elaboration check:** PULSE_MIN ≤ PULSE_CENTER ≤ PULSE_MAX < PERIOD_CYCLES.

## Structure
- **Package steering_pkg:**
  - CTRL_W = 48;
  - typedef enum logic [1:0] {IDLE, RUN, FAILSAFE} steer_state_t;
  - default timing constants.
- **Sub-module steer_target_clamp.** Combinational shift, add and clamp, plus a saturation flag. It is reused by the bench's reference model.
- The top module holds the capture register, period counter, FSM, rate limiter and miss counter.

## Test plan
Bench parameters: PERIOD_CYCLES=100, MIN=10, CENTER=15, MAX=20, CTRL_SHIFT=4, RATE_STEP=2, TIMEOUT=3.
1. Reset, then raise i_enable → o_pwm high 15 of every 100 cycles, aligned with o_period_start.
2. Command +48 (offset 3, target 18) → next periods widths 17, 18, 18; o_saturated=0.
3. Command −1600 from width 15 → target 10, o_saturated=1; widths 13, 11, 10.
4. Command −1 → target 14 (floor shift); command arriving exactly on the boundary cycle applies one period later.
5. Stop commands at width 18 → o_timeout=1 after 3 empty boundaries; widths ramp 16, 15; one command → RUN at next boundary, o_timeout=0.
6. Deassert rst mid-pulse, and separately drop i_enable at counter=5 → o_pwm 0 next cycle; width reads 15 after re-enable.

Source files
------------

// File: rtl/steering_pkg.sv
// Shared types and default timing for the steering PWM driver.
// Defaults assume a 50 MHz clock driving a standard hobby servo.
package steering_pkg;

    localparam int CTRL_W = 48;
    localparam int SUM_W  = CTRL_W + 2;

    localparam int DEF_PERIOD_CYCLES   = 1_000_000;
    localparam int DEF_PULSE_MIN       = 50_000;
    localparam int DEF_PULSE_CENTER    = 75_000;
    localparam int DEF_PULSE_MAX       = 100_000;
    localparam int DEF_CTRL_SHIFT      = 16;
    localparam int DEF_RATE_STEP       = 1_000;
    localparam int DEF_TIMEOUT_PERIODS = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        FAILSAFE = 2'd2
    } steer_state_t;

    // A zero minimum would allow a permanently-low output, which the servo reads as a lost signal.
    function automatic bit pulse_limits_ok(input int pmin, input int pcenter,
                                           input int pmax, input int period);
        return (pmin > 0) && (pmin <= pcenter) && (pcenter <= pmax) && (pmax < period);
    endfunction

endpackage

// File: rtl/steer_target_clamp.sv
// Maps a signed steering command to a pulse width: arithmetic shift, centre offset,
// clamp to the servo's mechanical limits, and flag when the clamp engaged.
module steer_target_clamp
    import steering_pkg::*;
#(
    parameter int W            = 20,
    parameter int CTRL_SHIFT   = DEF_CTRL_SHIFT,
    parameter int PULSE_MIN    = DEF_PULSE_MIN,
    parameter int PULSE_CENTER = DEF_PULSE_CENTER,
    parameter int PULSE_MAX    = DEF_PULSE_MAX
) (
    input  logic signed [CTRL_W-1:0] ctrl_value_i,
    output logic        [W-1:0]      target_o,
    output logic                     saturated_o
);

    localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(PULSE_MIN);
    localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(PULSE_CENTER);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(PULSE_MAX);

    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] offset;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        ext    = {{(SUM_W-CTRL_W){ctrl_value_i[CTRL_W-1]}}, ctrl_value_i};
        // Arithmetic shift floors toward minus infinity, so -1 maps to an offset of -1.
        offset = ext >>> CTRL_SHIFT;
        sum    = CENTER_S + offset;
        if (sum < MIN_S) begin
            target_o    = W'(PULSE_MIN);
            saturated_o = 1'b1;
        end else if (sum > MAX_S) begin
            target_o    = W'(PULSE_MAX);
            saturated_o = 1'b1;
        end else begin
            target_o    = sum[W-1:0];
            saturated_o = 1'b0;
        end
    end

endmodule

// File: rtl/steering_pwm_driver.sv
// Servo PWM driver: captures clamped steering targets, rate-limits the pulse width at
// period boundaries and falls back to the neutral pulse when commands stop arriving.
module steering_pwm_driver
    import steering_pkg::*;
#(
    parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
    parameter int PULSE_MIN       = DEF_PULSE_MIN,
    parameter int PULSE_CENTER    = DEF_PULSE_CENTER,
    parameter int PULSE_MAX       = DEF_PULSE_MAX,
    parameter int CTRL_SHIFT      = DEF_CTRL_SHIFT,
    parameter int RATE_STEP       = DEF_RATE_STEP,
    parameter int TIMEOUT_PERIODS = DEF_TIMEOUT_PERIODS,
    localparam int W              = $clog2(PERIOD_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_ctrl_valid,
    input  logic signed [CTRL_W-1:0] i_ctrl_value,
    input  logic                     i_enable,
    output logic                     o_pwm,
    output logic                     o_period_start,
    output logic        [W-1:0]      o_pulse_width,
    output logic                     o_saturated,
    output logic                     o_timeout,
    output steer_state_t             o_dbg_state
);

    localparam int MISS_W = $clog2(TIMEOUT_PERIODS + 1);

    localparam logic [W-1:0]      LAST_CNT = W'(PERIOD_CYCLES - 1);
    localparam logic [W-1:0]      CENTER_W = W'(PULSE_CENTER);
    localparam logic [W-1:0]      STEP_W   = W'(RATE_STEP);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(TIMEOUT_PERIODS);

    if (!pulse_limits_ok(PULSE_MIN, PULSE_CENTER, PULSE_MAX, PERIOD_CYCLES)) begin : g_limit_check
        $error("steering_pwm_driver: need 0 < PULSE_MIN <= PULSE_CENTER <= PULSE_MAX < PERIOD_CYCLES");
    end

    steer_state_t      state_q, state_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]      width_q, width_d;
    logic [W-1:0]      target_q, target_d;
    logic              sat_q, sat_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              seen_q, seen_d;
    logic              pwm_q, pwm_d;
    logic              pstart_q, pstart_d;

    logic         active;
    logic         running;
    logic         boundary;
    logic [W-1:0] clamp_target;
    logic         clamp_sat;
    logic [W-1:0] goal;
    logic [W-1:0] stepped;

    steer_target_clamp #(
        .W            (W),
        .CTRL_SHIFT   (CTRL_SHIFT),
        .PULSE_MIN    (PULSE_MIN),
        .PULSE_CENTER (PULSE_CENTER),
        .PULSE_MAX    (PULSE_MAX)
    ) u_clamp (
        .ctrl_value_i (i_ctrl_value),
        .target_o     (clamp_target),
        .saturated_o  (clamp_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = RUN;
                RUN:      if (boundary && (miss_d == MISS_MAX)) state_d = FAILSAFE;
                FAILSAFE: if (boundary && seen_q) state_d = RUN;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        active      = (state_q != IDLE);
        o_timeout   = (state_q == FAILSAFE);
        o_dbg_state = state_q;
    end

    // The enable gate makes a falling i_enable visible on the very next registered output.
    assign running  = active && i_enable;
    assign boundary = running && (cnt_q == LAST_CNT);

    always_comb begin
        goal = (state_q == FAILSAFE) ? CENTER_W : target_q;
        if (goal > width_q) begin
            stepped = ((goal - width_q) > STEP_W) ? (width_q + STEP_W) : goal;
        end else begin
            stepped = ((width_q - goal) > STEP_W) ? (width_q - STEP_W) : goal;
        end
    end

    always_comb begin
        cnt_d    = '0;
        width_d  = CENTER_W;
        pwm_d    = 1'b0;
        pstart_d = 1'b0;
        if (running) begin
            cnt_d    = (cnt_q == LAST_CNT) ? '0 : (cnt_q + 1'b1);
            width_d  = boundary ? stepped : width_q;
            pwm_d    = (cnt_q < width_q);
            pstart_d = (cnt_q == '0);
        end
    end

    // Capture runs in every state, so a command received while idle is ready at enable.
    always_comb begin
        target_d = i_ctrl_valid ? clamp_target : target_q;
        sat_d    = i_ctrl_valid ? clamp_sat    : sat_q;
        seen_d   = boundary ? i_ctrl_valid : (seen_q | i_ctrl_valid);
        miss_d   = miss_q;
        if (i_ctrl_valid) begin
            miss_d = '0;
        end else if (boundary && !seen_q && (miss_q < MISS_MAX)) begin
            miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            width_q  <= CENTER_W;
            target_q <= CENTER_W;
            sat_q    <= 1'b0;
            miss_q   <= '0;
            seen_q   <= 1'b0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            target_q <= target_d;
            sat_q    <= sat_d;
            miss_q   <= miss_d;
            seen_q   <= seen_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
        end
    end

    assign o_pwm          = pwm_q;
    assign o_period_start = pstart_q;
    assign o_pulse_width  = width_q;
    assign o_saturated    = sat_q;

endmodule
